// File: rtl/svc_rv_dmem_pkg.sv
// Shared types and helpers for the RV data-memory responder.
// Contents: response payload struct, bus-width constants, and the
// address-legality check used on every request.
package svc_rv_dmem_pkg;

   localparam int unsigned DMEM_LAT_MAX    = 4;
   localparam int unsigned DMEM_WSTRB_W    = 4;
   localparam int unsigned DMEM_DATA_W     = 32;
   localparam int unsigned DMEM_ADDR_MAX_W = 64;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } dmem_rsp_t;

   // Word-aligned and inside the array; callers zero-extend narrower addresses.
   function automatic logic dmem_addr_ok(input logic [DMEM_ADDR_MAX_W-1:0] addr,
                                         input logic [DMEM_ADDR_MAX_W-1:0] depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
   endfunction

endpackage

// File: rtl/svc_rv_dmem_rsp_fifo.sv
// Response queue for the data-memory responder: synchronous FIFO of dmem_rsp_t.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data at the tail
//   push_data   response payload
//   pop         drop the head entry
//   head        current head entry (meaningful while count != 0)
//   count       number of stored entries
// The upstream credit counter guarantees no push when full and no pop when empty.
module svc_rv_dmem_rsp_fifo
   import svc_rv_dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  dmem_rsp_t                  push_data,
   input  logic                       pop,
   output dmem_rsp_t                  head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   dmem_rsp_t         store [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Depth is generally not a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count qualifies every entry.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   assign head = store[rd_ptr];

endmodule

// File: rtl/svc_rv_dmem_resp.sv
// SRAM-backed responder for the RV core data-memory request/response bus.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_addr, req_we         byte address, 1 = write
//   req_wstrb, req_wdata     byte enables and write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       read data (0 for writes/errors), range/alignment error
// Optional build macro SVC_RV_DMEM_WAIT_EN: a 16-bit LFSR gates req_ready to
// inject pseudo-random wait states.
module svc_rv_dmem_resp
   import svc_rv_dmem_pkg::*;
#(
   parameter int unsigned AW          = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [AW-1:0]           req_addr,
   input  logic                    req_we,
   input  logic [DMEM_WSTRB_W-1:0] req_wstrb,
   input  logic [DMEM_DATA_W-1:0]  req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DMEM_DATA_W-1:0]  rsp_rdata,
   output logic                    rsp_err
);

   localparam int unsigned LAT = (LATENCY < 1) ? 1 :
                                 ((LATENCY > DMEM_LAT_MAX) ? DMEM_LAT_MAX : LATENCY);
   localparam int unsigned CAP = LAT + 1;
   localparam int unsigned CW  = $clog2(CAP + 1);
   localparam int unsigned IW  = $clog2(DEPTH_WORDS);

   logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

   logic            acc;
   logic            pop;
   logic            addr_ok;
   logic            room;
   logic [IW-1:0]   widx;
   logic [CW-1:0]   credits;
   logic [CW-1:0]   fifo_count;
   dmem_rsp_t       acc_rsp;
   dmem_rsp_t       push_d;
   dmem_rsp_t       head;
   logic            push_v;

   assign widx    = req_addr[IW+1:2];
   assign addr_ok = dmem_addr_ok(DMEM_ADDR_MAX_W'(req_addr), DMEM_ADDR_MAX_W'(DEPTH_WORDS));
   assign acc     = req_valid & req_ready;
   assign pop     = rsp_valid & rsp_ready;

   // A pop this cycle frees a credit in time for a same-cycle accept.
   assign room = (credits < CW'(CAP)) || pop;

`ifdef SVC_RV_DMEM_WAIT_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign req_ready = !rst && room && lfsr[0];
`else
   assign req_ready = !rst && room;
`endif

   // Credits cover responses in the pipeline plus those held in the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= '0;
      end else begin
         case ({acc, pop})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   // Writes commit at the accept edge so a read the next cycle sees them.
   always_ff @(posedge clk) begin
      if (acc && req_we && addr_ok) begin
         for (int b = 0; b < DMEM_WSTRB_W; b++) begin
            if (req_wstrb[b]) mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   // Response captured at accept time.
   always_comb begin
      acc_rsp.rdata = '0;
      acc_rsp.err   = !addr_ok;
      if (addr_ok && !req_we) acc_rsp.rdata = mem[widx];
   end

   // LAT-1 register stages; the FIFO write supplies the final cycle of latency.
   if (LAT == 1) begin : g_lat1
      assign push_v = acc;
      assign push_d = acc_rsp;
   end else begin : g_pipe
      logic [LAT-2:0] pv;
      dmem_rsp_t      pd [LAT-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            pv <= '0;
         end else begin
            pv[0] <= acc;
            for (int i = 1; i < int'(LAT) - 1; i++) pv[i] <= pv[i-1];
         end
      end

      always_ff @(posedge clk) begin
         pd[0] <= acc_rsp;
         for (int i = 1; i < int'(LAT) - 1; i++) pd[i] <= pd[i-1];
      end

      assign push_v = pv[LAT-2];
      assign push_d = pd[LAT-2];
   end

   svc_rv_dmem_rsp_fifo #(
      .DEPTH (CAP)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_v),
      .push_data (push_d),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   // Head is held in the FIFO until popped, so outputs stay stable under stall.
   assign rsp_valid = (fifo_count != '0);
   assign rsp_rdata = rsp_valid ? head.rdata : '0;
   assign rsp_err   = rsp_valid & head.err;

endmodule
